// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the cache_sys physical-memory arbiter.
// Arbiter FSM states, grant owners and the pmem data width.
package pmem_arb_types;

    localparam int PMEM_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/pmem_arbiter_beat_counter.sv
// Counts pmem response beats within one burst.
// last_beat is combinational so the FSM can leave its grant on that edge.
module burst_beat_counter #(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last_beat
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

    logic [CW-1:0] cnt;

    assign last_beat = inc & (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || last_beat) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one 64-bit pmem port between I-cache fills and D-cache fill/write-back.
// A grant is held for BURST_LEN response beats, then one idle bubble follows.
module pmem_arbiter
    import pmem_arb_types::*;
#(
    parameter int BURST_LEN   = 4,
    parameter bit DCACHE_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [63:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [63:0] pmem_wdata,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
);

    arb_state_t state;
    arb_state_t state_nx;
    arb_owner_t last_grant;

    logic d_req;
    logic in_grant;
    logic beat_inc;
    logic last_beat;
    logic pick_d;

    assign d_req    = d_read | d_write;
    assign in_grant = (state == GRANT_I) || (state == GRANT_D);
    assign beat_inc = pmem_resp & in_grant;

    // On a tie, round-robin hands the port to whoever did not own it last.
    assign pick_d = DCACHE_PRIO || (last_grant == OWNER_I);

    burst_beat_counter #(
        .BURST_LEN(BURST_LEN)
    ) u_beats (
        .clk      (clk),
        .rst      (rst),
        .clr      (~in_grant),
        .inc      (beat_inc),
        .last_beat(last_beat)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (i_read && d_req) begin
                    state_nx = pick_d ? GRANT_D : GRANT_I;
                end else if (d_req) begin
                    state_nx = GRANT_D;
                end else if (i_read) begin
                    state_nx = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (last_beat) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWNER_I;
        end else begin
            state <= state_nx;
            if (last_beat) begin
                last_grant <= (state == GRANT_D) ? OWNER_D : OWNER_I;
            end
        end
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state)
            GRANT_I: begin
                pmem_read    = i_read;
                pmem_address = i_address;
            end
            GRANT_D: begin
                // A simultaneous read+write request is serviced as a write.
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

    assign i_resp  = pmem_resp & (state == GRANT_I);
    assign d_resp  = pmem_resp & (state == GRANT_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: round-robin instance and D-priority instance.
// Both share stimulus; each scenario checks the instance it targets.
module tb_pmem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [63:0] d_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    logic [63:0] i_rdata0, d_rdata0, pmem_wdata0;
    logic        i_resp0, d_resp0, pmem_read0, pmem_write0;
    logic [31:0] pmem_address0;

    logic [63:0] i_rdata1, d_rdata1, pmem_wdata1;
    logic        i_resp1, d_resp1, pmem_read1, pmem_write1;
    logic [31:0] pmem_address1;

    int checks;
    int errors;

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h8000_0040;

    pmem_arbiter #(.BURST_LEN(4), .DCACHE_PRIO(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata0), .i_resp(i_resp0),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata0), .d_resp(d_resp0),
        .pmem_read(pmem_read0), .pmem_write(pmem_write0),
        .pmem_address(pmem_address0), .pmem_wdata(pmem_wdata0),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    pmem_arbiter #(.BURST_LEN(4), .DCACHE_PRIO(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata1), .i_resp(i_resp1),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_resp(d_resp1),
        .pmem_read(pmem_read1), .pmem_write(pmem_write1),
        .pmem_address(pmem_address1), .pmem_wdata(pmem_wdata1),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_read = 0; d_read = 0; d_write = 0;
        i_address = IA; d_address = DA; d_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        i_read = 0; d_read = 0; d_write = 0;
        i_address = IA; d_address = DA; d_wdata = 64'hFFFF;
        pmem_resp = 0; pmem_rdata = '0;
        rst = 1;
        tick();
        checks++;
        if ({pmem_read0, pmem_write0, i_resp0, d_resp0} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {pmem_read0, pmem_write0, i_resp0, d_resp0});
        end
        checks++;
        if (pmem_address0 !== 32'h0 || pmem_wdata0 !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus addr %h wdata %h want 0",
                     pmem_address0, pmem_wdata0);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_solo_i();
        logic [63:0] v;
        do_reset();
        i_read = 1;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0) begin
            errors++;
            $display("FAIL solo_i_early pmem_read %b want 0", pmem_read0);
        end
        tick();
        checks++;
        if (pmem_read0 !== 1'b1 || pmem_address0 !== IA || pmem_write0 !== 1'b0) begin
            errors++;
            $display("FAIL solo_i_strobe rd %b wr %b addr %h want 1 0 %h",
                     pmem_read0, pmem_write0, pmem_address0, IA);
        end
        for (int b = 0; b < 4; b++) begin
            v = 64'h1111_2222_0000_0000 + 64'(b);
            pmem_rdata = v;
            pmem_resp = 1;
            #1;
            checks++;
            if (i_resp0 !== 1'b1 || i_rdata0 !== v || d_resp0 !== 1'b0) begin
                errors++;
                $display("FAIL solo_i_beat%0d i_resp %b d_resp %b data %h want 1 0 %h",
                         b, i_resp0, d_resp0, i_rdata0, v);
            end
            tick();
            if (b == 3) i_read = 0;
        end
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0 || pmem_address0 !== 32'h0) begin
            errors++;
            $display("FAIL solo_i_idle rd %b addr %h want 0 0",
                     pmem_read0, pmem_address0);
        end
    endtask

    task automatic test_solo_d_write();
        logic [63:0] w;
        do_reset();
        d_write = 1;
        d_wdata = 64'hA;
        tick();
        checks++;
        if (pmem_write0 !== 1'b1 || pmem_read0 !== 1'b0 || pmem_address0 !== DA) begin
            errors++;
            $display("FAIL solo_d_strobe wr %b rd %b addr %h want 1 0 %h",
                     pmem_write0, pmem_read0, pmem_address0, DA);
        end
        for (int b = 0; b < 4; b++) begin
            w = 64'hA + 64'(b);
            d_wdata = w;
            pmem_resp = 1;
            #1;
            checks++;
            if (pmem_wdata0 !== w || d_resp0 !== 1'b1 ||
                pmem_read0 !== 1'b0 || i_resp0 !== 1'b0) begin
                errors++;
                $display("FAIL solo_d_beat%0d wdata %h d_resp %b rd %b i_resp %b want %h 1 0 0",
                         b, pmem_wdata0, d_resp0, pmem_read0, i_resp0, w);
            end
            tick();
            if (b == 3) d_write = 0;
        end
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_write0 !== 1'b0 || pmem_wdata0 !== 64'h0) begin
            errors++;
            $display("FAIL solo_d_idle wr %b wdata %h want 0 0",
                     pmem_write0, pmem_wdata0);
        end
    endtask

    task automatic test_tie_round_robin();
        do_reset();
        i_read = 1;
        d_read = 1;
        tick();
        checks++;
        if (pmem_read0 !== 1'b1 || pmem_address0 !== DA) begin
            errors++;
            $display("FAIL rr_first rd %b addr %h want 1 %h",
                     pmem_read0, pmem_address0, DA);
        end
        for (int b = 0; b < 4; b++) begin
            pmem_rdata = 64'hD0 + 64'(b);
            pmem_resp = 1;
            #1;
            checks++;
            if (d_resp0 !== 1'b1 || i_resp0 !== 1'b0) begin
                errors++;
                $display("FAIL rr_d_beat%0d d_resp %b i_resp %b want 1 0",
                         b, d_resp0, i_resp0);
            end
            tick();
            if (b == 3) d_read = 0;
        end
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0 || pmem_address0 !== 32'h0) begin
            errors++;
            $display("FAIL rr_bubble rd %b addr %h want 0 0",
                     pmem_read0, pmem_address0);
        end
        tick();
        checks++;
        if (pmem_read0 !== 1'b1 || pmem_address0 !== IA) begin
            errors++;
            $display("FAIL rr_second rd %b addr %h want 1 %h",
                     pmem_read0, pmem_address0, IA);
        end
        for (int b = 0; b < 4; b++) begin
            pmem_resp = 1;
            #1;
            checks++;
            if (i_resp0 !== 1'b1 || d_resp0 !== 1'b0) begin
                errors++;
                $display("FAIL rr_i_beat%0d i_resp %b d_resp %b want 1 0",
                         b, i_resp0, d_resp0);
            end
            tick();
            if (b == 3) i_read = 0;
        end
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0) begin
            errors++;
            $display("FAIL rr_done rd %b want 0", pmem_read0);
        end
    endtask

    task automatic test_tie_fixed_prio();
        do_reset();
        i_read = 1;
        d_read = 1;
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if (pmem_address1 !== DA || pmem_read1 !== 1'b1) begin
                errors++;
                $display("FAIL prio_tie%0d addr %h rd %b want %h 1",
                         r, pmem_address1, pmem_read1, DA);
            end
            if (r == 1) begin
                checks++;
                if (pmem_address0 !== IA) begin
                    errors++;
                    $display("FAIL rr_contrast addr %h want %h", pmem_address0, IA);
                end
            end
            for (int b = 0; b < 4; b++) begin
                pmem_resp = 1;
                tick();
                if (r == 1 && b == 3) d_read = 0;
            end
            pmem_resp = 0;
            #1;
            checks++;
            if (pmem_read1 !== 1'b0) begin
                errors++;
                $display("FAIL prio_bubble%0d rd %b want 0", r, pmem_read1);
            end
        end
        tick();
        checks++;
        if (pmem_address1 !== IA || pmem_read1 !== 1'b1) begin
            errors++;
            $display("FAIL prio_i_served addr %h rd %b want %h 1",
                     pmem_address1, pmem_read1, IA);
        end
        i_read = 0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        i_read = 1;
        tick();
        for (int b = 0; b < 2; b++) begin
            pmem_resp = 1;
            tick();
        end
        pmem_resp = 0;
        rst = 1;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0 || pmem_address0 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset rd %b addr %h want 0 0",
                     pmem_read0, pmem_address0);
        end
        tick();
        rst = 0;
        i_read = 0;
        d_read = 1;
        tick();
        checks++;
        if (pmem_read0 !== 1'b1 || pmem_address0 !== DA) begin
            errors++;
            $display("FAIL post_reset_grant rd %b addr %h want 1 %h",
                     pmem_read0, pmem_address0, DA);
        end
        for (int b = 0; b < 3; b++) begin
            pmem_resp = 1;
            tick();
        end
        #1;
        checks++;
        if (pmem_read0 !== 1'b1 || pmem_address0 !== DA) begin
            errors++;
            $display("FAIL post_reset_len3 rd %b addr %h want 1 %h",
                     pmem_read0, pmem_address0, DA);
        end
        tick();
        d_read = 0;
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_len4 rd %b want 0", pmem_read0);
        end
    endtask

    task automatic test_idle_resp_ignored();
        do_reset();
        pmem_resp = 1;
        #1;
        checks++;
        if (i_resp0 !== 1'b0 || d_resp0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp i_resp %b d_resp %b want 0 0", i_resp0, d_resp0);
        end
        tick();
        pmem_resp = 0;
        i_read = 1;
        tick();
        for (int b = 0; b < 3; b++) begin
            pmem_resp = 1;
            tick();
        end
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_read0 !== 1'b1) begin
            errors++;
            $display("FAIL idle_resp_count rd %b want 1", pmem_read0);
        end
        pmem_resp = 1;
        tick();
        i_read = 0;
        pmem_resp = 0;
        #1;
        checks++;
        if (pmem_read0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp_done rd %b want 0", pmem_read0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        test_reset();
        test_solo_i();
        test_solo_d_write();
        test_tie_round_robin();
        test_tie_fixed_prio();
        test_reset_mid_burst();
        test_idle_resp_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
